// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter in front of the slave-decode bus.
// A registered grant routes one master at a time; a per-transaction timeout keeps a hung slave from locking the CPU.
module wb_arbiter_2m #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int ROUND_ROBIN    = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  input  logic                  s_ack_i,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  output logic [1:0]            grant_o,
  output logic                  busy_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t           state_q;
  logic [1:0]       grant_q;
  logic             busy_q;
  logic             last_q;   // 0 = m0 was last served, 1 = m1
  logic [CNT_W-1:0] cnt_q;

  logic                  g0, g1;
  logic                  sel_stb, sel_we;
  logic [ADDR_WIDTH-1:0] sel_adr;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic                  to_hit, ack_any;
  logic [DATA_WIDTH-1:0] rdat;

  assign g0 = (state_q == GNT0);
  assign g1 = (state_q == GNT1);

  always_comb begin
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_adr = '0;
    sel_dat = '0;
    if (g0) begin
      sel_stb = m0_stb_i;
      sel_we  = m0_we_i;
      sel_adr = m0_adr_i;
      sel_dat = m0_dat_i;
    end else if (g1) begin
      sel_stb = m1_stb_i;
      sel_we  = m1_we_i;
      sel_adr = m1_adr_i;
      sel_dat = m1_dat_i;
    end
  end

  // A same-cycle ack always beats the timeout; an aborted strobe never times out.
  assign to_hit  = TO_EN && sel_stb && !s_ack_i && (cnt_q == LIMIT);
  assign ack_any = s_ack_i || to_hit;
  assign rdat    = to_hit ? {DATA_WIDTH{1'b1}} : s_dat_i;

  assign s_stb_o = sel_stb && !to_hit;
  assign s_we_o  = sel_we;
  assign s_adr_o = sel_adr;
  assign s_dat_o = sel_dat;

  assign m0_ack_o = g0 && ack_any;
  assign m0_err_o = g0 && to_hit;
  assign m0_dat_o = g0 ? rdat : '0;
  assign m1_ack_o = g1 && ack_any;
  assign m1_err_o = g1 && to_hit;
  assign m1_dat_o = g1 ? rdat : '0;

  assign grant_o = grant_q;
  assign busy_o  = busy_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      busy_q  <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (m0_stb_i && (!m1_stb_i || ROUND_ROBIN == 0 || last_q)) begin
            state_q <= GNT0;
            grant_q <= 2'b01;
            busy_q  <= 1'b1;
          end else if (m1_stb_i) begin
            state_q <= GNT1;
            grant_q <= 2'b10;
            busy_q  <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (ack_any) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
            last_q  <= g1;
          end else if (!sel_stb) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
          end else if (TO_EN && cnt_q != LIMIT) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench: a fixed-priority and a round-robin arbiter (both with a 4-cycle timeout) share one stimulus stream.
module tb_wb_arbiter_2m;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_stb, m0_we, m1_stb, m1_we, s_ack;
  logic [15:0] m0_adr, m1_adr;
  logic [7:0]  m0_dat, m1_dat, s_dat;

  logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_s_stb, a_s_we, a_busy;
  logic [7:0]  a_m0_dat, a_m1_dat, a_s_dat;
  logic [15:0] a_s_adr;
  logic [1:0]  a_grant;
  logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_s_stb, b_s_we, b_busy;
  logic [7:0]  b_m0_dat, b_m1_dat, b_s_dat;
  logic [15:0] b_s_adr;
  logic [1:0]  b_grant;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter_2m #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(4)) u_fp (
    .clk_i(clk), .rst_i(rst),
    .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
    .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err), .m0_dat_o(a_m0_dat),
    .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
    .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err), .m1_dat_o(a_m1_dat),
    .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_adr_o(a_s_adr), .s_dat_o(a_s_dat),
    .s_ack_i(s_ack), .s_dat_i(s_dat), .grant_o(a_grant), .busy_o(a_busy)
  );

  wb_arbiter_2m #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(4)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
    .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err), .m0_dat_o(b_m0_dat),
    .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
    .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err), .m1_dat_o(b_m1_dat),
    .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_adr_o(b_s_adr), .s_dat_o(b_s_dat),
    .s_ack_i(s_ack), .s_dat_i(s_dat), .grant_o(b_grant), .busy_o(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0;
    m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0; s_ack = 0; s_dat = '0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst_grant_a", a_grant, 2'b00);
    chk("rst_grant_b", b_grant, 2'b00);
    chk("rst_busy", a_busy, 0);
    chk("rst_sstb", a_s_stb, 0);
    chk("rst_sadr", a_s_adr, 0);
    chk("rst_m0ack", a_m0_ack, 0);

    // Single master read
    m0_stb = 1; m0_we = 0; m0_adr = 16'h0080;
    #1;
    chk("idle_sstb", a_s_stb, 0);
    tick();
    chk("t1_grant", a_grant, 2'b01);
    chk("t1_busy", a_busy, 1);
    chk("t1_sstb", a_s_stb, 1);
    chk("t1_sadr", a_s_adr, 16'h0080);
    chk("t1_swe", a_s_we, 0);
    chk("t1_noack", a_m0_ack, 0);
    tick();
    s_ack = 1; s_dat = 8'h5A;
    #1;
    chk("t1_ack", a_m0_ack, 1);
    chk("t1_dat", a_m0_dat, 8'h5A);
    chk("t1_err", a_m0_err, 0);
    chk("t1_m1ack", a_m1_ack, 0);
    chk("t1_m1dat", a_m1_dat, 0);
    chk("t1_rr_dat", b_m0_dat, 8'h5A);
    tick();
    m0_stb = 0; s_ack = 0; s_dat = 0;
    #1;
    chk("t1_idle_grant", a_grant, 2'b00);
    chk("t1_idle_busy", a_busy, 0);

    // Contention, slave acks every strobe cycle
    rst = 0; tick(); rst = 1;
    m0_stb = 1; m0_adr = 16'h0010;
    m1_stb = 1; m1_we = 1; m1_adr = 16'hF123; m1_dat = 8'hC3;
    s_ack = 1; s_dat = 8'h11;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("fp_grant", a_grant, 2'b01);
      chk("fp_m1ack", a_m1_ack, 0);
      chk("rr_grant", b_grant, (i % 2 == 1) ? 2'b10 : 2'b01);
      if (i % 2 == 1) begin
        chk("rr_swe", b_s_we, 1);
        chk("rr_sadr", b_s_adr, 16'hF123);
        chk("rr_sdat", b_s_dat, 8'hC3);
        chk("rr_m1ack", b_m1_ack, 1);
        chk("rr_m0ack", b_m0_ack, 0);
      end else begin
        chk("rr_m0ack", b_m0_ack, 1);
      end
      tick();
      chk("fp_gap", a_grant, 2'b00);
      chk("rr_gap", b_grant, 2'b00);
    end
    m0_stb = 0;
    tick();
    chk("fp_m1_after_drop", a_grant, 2'b10);
    tick();
    m1_stb = 0; s_ack = 0;
    tick();
    chk("fp_back_idle", a_grant, 2'b00);

    // Timeout: m1 request, slave silent
    m1_stb = 1;
    tick();
    chk("to_grant", a_grant, 2'b10);
    for (int k = 0; k < 4; k++) begin
      chk("to_sstb_wait", a_s_stb, 1);
      chk("to_noack_wait", a_m1_ack, 0);
      tick();
    end
    chk("to_ack", a_m1_ack, 1);
    chk("to_err", a_m1_err, 1);
    chk("to_dat", a_m1_dat, 8'hFF);
    chk("to_sstb", a_s_stb, 0);
    chk("to_m0ack", a_m0_ack, 0);
    chk("to_rr_err", b_m1_err, 1);
    tick();
    m1_stb = 0; s_ack = 1; s_dat = 8'h77;
    #1;
    chk("late_grant", a_grant, 2'b00);
    chk("late_m1ack", a_m1_ack, 0);
    chk("late_m0ack", a_m0_ack, 0);
    chk("late_m1dat", a_m1_dat, 0);
    tick();
    s_ack = 0;

    // Ack in the 4th wait cycle
    m0_stb = 1; m0_we = 0;
    tick();
    chk("al_grant", a_grant, 2'b01);
    tick(); tick(); tick();
    s_ack = 1; s_dat = 8'hA5;
    #1;
    chk("al_ack", a_m0_ack, 1);
    chk("al_err", a_m0_err, 0);
    chk("al_dat", a_m0_dat, 8'hA5);
    tick();
    m0_stb = 0; s_ack = 0;
    tick();

    // Ack coincident with the timeout limit
    m0_stb = 1;
    tick();
    tick(); tick(); tick(); tick();
    s_ack = 1; s_dat = 8'h3C;
    #1;
    chk("co_ack", a_m0_ack, 1);
    chk("co_err", a_m0_err, 0);
    chk("co_dat", a_m0_dat, 8'h3C);
    chk("co_sstb", a_s_stb, 1);
    tick();
    m0_stb = 0; s_ack = 0;
    tick();

    // Abort, then contention follows last grant (m0)
    m0_stb = 1;
    tick();
    chk("ab_grant", a_grant, 2'b01);
    m0_stb = 0;
    #1;
    chk("ab_noack", a_m0_ack, 0);
    chk("ab_sstb", a_s_stb, 0);
    tick();
    chk("ab_idle_a", a_grant, 2'b00);
    chk("ab_idle_b", b_grant, 2'b00);
    m0_stb = 1; m1_stb = 1;
    tick();
    chk("ab_fp_next", a_grant, 2'b01);
    chk("ab_rr_next", b_grant, 2'b10);

    // Reset while m1 is granted
    rst = 0;
    tick();
    chk("mr_grant", b_grant, 2'b00);
    chk("mr_sstb", b_s_stb, 0);
    chk("mr_m1ack", b_m1_ack, 0);
    chk("mr_fp_grant", a_grant, 2'b00);
    rst = 1; m0_stb = 0; m1_stb = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
